// File: rtl/halving_sequencer.sv
// ============================================================================
// halving_sequencer
//
// Purpose:
//   Loads an unsigned seed and shifts it right by one bit per clock until it
//   reaches zero. Every completed halving produces a step_valid pulse. A run
//   ends with a one-cycle done pulse, unless it is aborted.
//
// Ports:
//   clk        in   1      single clock, rising-edge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      begin a run (accepted only while ready)
//   seed       in   WIDTH  initial value, sampled with start
//   abort      in   1      cancel a run in LOAD/RUN (wins over start and hold)
//   hold       in   1      (HALVING_SEQ_HOLD_EN only) stall RUN while high
//   ready      out  1      state == IDLE
//   busy       out  1      state == LOAD or RUN
//   value      out  WIDTH  current halved value
//   step_valid out  1      pulses once per completed halving
//   step_count out  CW     halvings completed in the current run
//   done       out  1      one-cycle pulse when a run finishes at zero
//
// Configuration:
//   HALVING_SEQ_HOLD_EN  adds the hold input. Without it RUN never stalls.
//
// States:
//   IDLE | waiting for start; value/step_count hold the last result
//   LOAD | seed captured; decide between RUN and DONE (zero seed)
//   RUN  | one halving per clock until the value reaches zero
//   DONE | done pulse is high for this single cycle
// ============================================================================
module halving_sequencer #(
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic             abort,
`ifdef HALVING_SEQ_HOLD_EN
    input  logic             hold,
`endif
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] value,
    output logic             step_valid,
    output logic [CW-1:0]    step_count,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] STEP_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] STEP_ONE = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    logic [CW-1:0]    r_step_count;
    logic             r_step_valid;
    logic             r_done;

    logic [WIDTH-1:0] w_half;
    logic             w_hold;

    assign w_half = r_value >> 1;

`ifdef HALVING_SEQ_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_value      <= '0;
            r_step_count <= '0;
            r_step_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // Both pulses default low; only the branches below raise them.
            r_step_valid <= 1'b0;
            r_done       <= 1'b0;

            case (r_state)
                IDLE: begin
                    // abort beats a simultaneous start.
                    if (start && !abort) begin
                        r_value      <= seed;
                        r_step_count <= '0;
                        r_state      <= LOAD;
                    end
                end

                LOAD: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (r_value == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    if (abort) begin
                        // Abort also wins over the final halving. The value
                        // and count stay as they were before this edge.
                        r_state <= IDLE;
                    end else if (!w_hold) begin
                        r_value      <= w_half;
                        r_step_valid <= 1'b1;
                        // A WIDTH-bit value reaches zero after at most WIDTH
                        // halvings. The saturation guard keeps the count from
                        // wrapping even if that bound were ever broken.
                        if (r_step_count != STEP_MAX) begin
                            r_step_count <= r_step_count + STEP_ONE;
                        end
                        if (w_half == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready      = (r_state == IDLE);
    assign busy       = (r_state == LOAD) || (r_state == RUN);
    assign value      = r_value;
    assign step_valid = r_step_valid;
    assign step_count = r_step_count;
    assign done       = r_done;

endmodule

// File: tb/tb_halving_sequencer.sv
// ============================================================================
// tb_halving_sequencer
//
// Directed testbench for halving_sequencer with WIDTH=64. Each scenario task
// drives its own stimulus and checks the outputs against values computed by
// hand. Outputs are sampled 1 ns after each rising edge.
// ============================================================================
module tb_halving_sequencer;

    localparam int WIDTH = 64;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] seed;
    logic             abort;
`ifdef HALVING_SEQ_HOLD_EN
    logic             hold;
`endif
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] value;
    logic             step_valid;
    logic [CW-1:0]    step_count;
    logic             done;

    int n_checks;
    int n_fail;

    halving_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .abort      (abort),
`ifdef HALVING_SEQ_HOLD_EN
        .hold       (hold),
`endif
        .ready      (ready),
        .busy       (busy),
        .value      (value),
        .step_valid (step_valid),
        .step_count (step_count),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if (value !== '0 || step_count !== '0 || step_valid !== 1'b0 ||
            done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_initial: value=%0h step_count=%0d step_valid=%b done=%b busy=%b ready=%b, want 0 0 0 0 0 1",
                     value, step_count, step_valid, done, busy, ready);
        end
        #4 rst = 1'b0;

        // Start must be accepted on the first edge after reset is released.
        seed  = 64'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || value !== 64'hFF) begin
            n_fail++;
            $display("FAIL reset_first_start: busy=%b value=%0h, want 1 ff", busy, value);
        end
        tick();   // RUN
        tick();   // 7f
        tick();   // 3f
        n_checks++;
        if (value !== 64'h3F || step_count !== 7'd2) begin
            n_fail++;
            $display("FAIL reset_midrun_pre: value=%0h step_count=%0d, want 3f 2", value, step_count);
        end

        // Assert reset between edges. It must act without a clock edge.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (value !== '0 || step_count !== '0 || step_valid !== 1'b0 ||
            done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midrun: value=%0h step_count=%0d step_valid=%b done=%b busy=%b ready=%b, want 0 0 0 0 0 1",
                     value, step_count, step_valid, done, busy, ready);
        end
        #1 rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_seed8();
        seed  = 64'd8;
        start = 1'b1;
        tick();               // edge 1: LOAD
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || ready !== 1'b0 || value !== 64'd8 ||
            step_count !== '0 || step_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seed8_load: busy=%b ready=%b value=%0d step_count=%0d step_valid=%b, want 1 0 8 0 0",
                     busy, ready, value, step_count, step_valid);
        end
        tick();               // edge 2: RUN
        n_checks++;
        if (step_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL seed8_run_entry: step_valid=%b busy=%b done=%b, want 0 1 0", step_valid, busy, done);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();           // edges 3..6
            n_checks++;
            if (step_valid !== 1'b1 || value !== (64'd8 >> i) || step_count !== CW'(i) ||
                done !== (i == 4)) begin
                n_fail++;
                $display("FAIL seed8_step%0d: step_valid=%b value=%0d step_count=%0d done=%b, want 1 %0d %0d %b",
                         i, step_valid, value, step_count, done, 64'd8 >> i, i, (i == 4));
            end
        end
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL seed8_done_state: busy=%b ready=%b, want 0 0", busy, ready);
        end
        tick();               // edge 7: IDLE
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || step_valid !== 1'b0 ||
            value !== '0 || step_count !== 7'd4) begin
            n_fail++;
            $display("FAIL seed8_idle: ready=%b done=%b step_valid=%b value=%0d step_count=%0d, want 1 0 0 0 4",
                     ready, done, step_valid, value, step_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_seed0();
        int sv_seen;
        sv_seen = 0;
        seed  = '0;
        start = 1'b1;
        tick();               // edge 1
        start = 1'b0;
        if (step_valid === 1'b1) sv_seen++;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL seed0_load: done=%b busy=%b, want 0 1", done, busy);
        end
        tick();               // edge 2
        if (step_valid === 1'b1) sv_seen++;
        n_checks++;
        if (done !== 1'b1 || step_count !== '0 || value !== '0) begin
            n_fail++;
            $display("FAIL seed0_done: done=%b step_count=%0d value=%0h, want 1 0 0", done, step_count, value);
        end
        tick();               // edge 3
        if (step_valid === 1'b1) sv_seen++;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || sv_seen != 0) begin
            n_fail++;
            $display("FAIL seed0_idle: ready=%b done=%b step_valid_seen=%0d, want 1 0 0", ready, done, sv_seen);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_wide();
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] exp_v;
        int               bad;
        s   = 64'h8000_0000_0000_0000;
        bad = 0;
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 1; i <= 64; i++) begin
            // Stray start requests in the middle of the run must be ignored.
            if (i == 10 || i == 40) begin
                seed  = 64'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            exp_v = s >> i;
            n_checks++;
            if (step_valid !== 1'b1 || value !== exp_v || step_count !== CW'(i) ||
                done !== (i == 64)) begin
                n_fail++;
                bad++;
                if (bad <= 4)
                    $display("FAIL wide_step%0d: step_valid=%b value=%0h step_count=%0d done=%b, want 1 %0h %0d %b",
                             i, step_valid, value, step_count, done, exp_v, i, (i == 64));
            end
        end
        start = 1'b0;
        n_checks++;
        if (step_count !== 7'd64 || value !== '0) begin
            n_fail++;
            $display("FAIL wide_final: step_count=%0d value=%0h, want 64 0", step_count, value);
        end
        tick();
        n_checks++;
        if (ready !== 1'b1 || step_count !== 7'd64) begin
            n_fail++;
            $display("FAIL wide_idle: ready=%b step_count=%0d, want 1 64", ready, step_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort();
        seed  = 64'd5;
        start = 1'b1;
        tick();               // LOAD
        start = 1'b0;
        tick();               // RUN
        tick();               // step 1: value 2
        n_checks++;
        if (value !== 64'd2 || step_count !== 7'd1 || step_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_step1: value=%0d step_count=%0d step_valid=%b, want 2 1 1", value, step_count, step_valid);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || value !== 64'd2 ||
            step_count !== 7'd1 || step_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: ready=%b done=%b value=%0d step_count=%0d step_valid=%b, want 1 0 2 1 0",
                     ready, done, value, step_count, step_valid);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || ready !== 1'b1 || value !== 64'd2) begin
            n_fail++;
            $display("FAIL abort_after: done=%b ready=%b value=%0d, want 0 1 2", done, ready, value);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_start_abort_idle();
        seed  = 64'd9;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || value !== 64'd2 || step_count !== 7'd1) begin
            n_fail++;
            $display("FAIL start_abort_idle: ready=%b busy=%b value=%0d step_count=%0d, want 1 0 2 1",
                     ready, busy, value, step_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort_final();
        seed  = 64'd1;
        start = 1'b1;
        tick();               // LOAD
        start = 1'b0;
        tick();               // RUN, next edge would be the final halving
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || step_valid !== 1'b0 ||
            value !== 64'd1 || step_count !== '0) begin
            n_fail++;
            $display("FAIL abort_final: ready=%b done=%b step_valid=%b value=%0d step_count=%0d, want 1 0 0 1 0",
                     ready, done, step_valid, value, step_count);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_final_nodone: done=%b, want 0", done);
        end
    endtask

`ifdef HALVING_SEQ_HOLD_EN
    // ------------------------------------------------------------------
    task automatic test_hold();
        seed  = 64'd16;
        start = 1'b1;
        tick();               // LOAD
        start = 1'b0;
        tick();               // RUN
        tick();               // 8, step 1
        tick();               // 4, step 2
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (value !== 64'd4 || step_valid !== 1'b0 || step_count !== 7'd2 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: value=%0d step_valid=%b step_count=%0d busy=%b, want 4 0 2 1",
                         i, value, step_valid, step_count, busy);
            end
        end
        hold = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            tick();
            n_checks++;
            if (step_valid !== 1'b1 || value !== (64'd16 >> i) || step_count !== CW'(i) ||
                done !== (i == 5)) begin
                n_fail++;
                $display("FAIL hold_step%0d: step_valid=%b value=%0d step_count=%0d done=%b, want 1 %0d %0d %b",
                         i, step_valid, value, step_count, done, 64'd16 >> i, i, (i == 5));
            end
        end
        tick();
        n_checks++;
        if (ready !== 1'b1 || step_count !== 7'd5) begin
            n_fail++;
            $display("FAIL hold_idle: ready=%b step_count=%0d, want 1 5", ready, step_count);
        end
    endtask
`endif

    // ------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        seed     = '0;
        abort    = 1'b0;
`ifdef HALVING_SEQ_HOLD_EN
        hold     = 1'b0;
`endif
        test_reset();
        test_seed8();
        test_seed0();
        test_wide();
        test_abort();
        test_start_abort_idle();
        test_abort_final();
`ifdef HALVING_SEQ_HOLD_EN
        test_hold();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
